// File: rtl/audio_pkg.sv
// Shared constants and width helpers for the serial audio transmitter.
// Mode encodings match the mode_i pin of tdm_audio_tx.
package audio_pkg;

    localparam logic AUDIO_MODE_I2S = 1'b0;
    localparam logic AUDIO_MODE_TDM = 1'b1;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned ctr_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned frame_bits(input int unsigned num_ch,
                                               input int unsigned slot_w);
        return num_ch * slot_w;
    endfunction

    function automatic bit slot_fits(input int unsigned audio_dw,
                                     input int unsigned slot_w);
        return slot_w >= audio_dw;
    endfunction

endpackage

// File: rtl/audio_bclk_gen.sv
// Bit clock generator: divides clk_i down to sck_o and flags the cycle
// on which sck_o falls so the transmitter can launch the next bit.
module audio_bclk_gen
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sck_o,
    output logic fall_tick_o
);

    localparam int DIV_W = ctr_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap        = (div_cnt == DIV_LAST);
    assign fall_tick_o = en_i & ~rst_i & wrap & sck_o;

    // Disabling parks the divider at zero with sck low, so every enable
    // restarts with a full low half-period before the first rising edge.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            div_cnt <= '0;
            sck_o   <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            sck_o   <= ~sck_o;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_audio_tx.sv
// Parametrised I2S / TDM (DSP-A) serial audio transmitter with a
// double-buffered valid/ready frame input and sticky underrun flag.
module tdm_audio_tx
    import audio_pkg::*;
#(
    parameter int AUDIO_DW = 8,
    parameter int SLOT_W   = 16,
    parameter int NUM_CH   = 2,
    parameter int CLK_DIV  = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       mode_i,
    input  logic [NUM_CH*AUDIO_DW-1:0] sample_i,
    input  logic                       sample_valid_i,
    output logic                       sample_ready_o,
    input  logic                       underrun_clr_i,
    output logic                       sck_o,
    output logic                       ws_o,
    output logic                       sd_o,
    output logic                       frame_start_o,
    output logic                       underrun_o
);

    localparam int FRAME_W = frame_bits(NUM_CH, SLOT_W);
    localparam int BIT_W   = ctr_width(SLOT_W);
    localparam int SLOT_CW = ctr_width(NUM_CH);
    localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(SLOT_W - 1);
    localparam logic [SLOT_CW-1:0] SLOT_LAST = SLOT_CW'(NUM_CH - 1);

    logic                       fall_tick;
    logic [BIT_W-1:0]           bit_cnt;
    logic [BIT_W-1:0]           bit_nxt;
    logic [SLOT_CW-1:0]         slot_cnt;
    logic [SLOT_CW-1:0]         slot_nxt;
    logic                       boundary;
    logic                       ws_nxt;
    logic                       mode_q;
    logic                       load;
    logic [NUM_CH*AUDIO_DW-1:0] holding;
    logic                       holding_full;
    logic [FRAME_W-1:0]         shift_reg;
    logic [FRAME_W-1:0]         frame_word;
    logic [FRAME_W-1:0]         load_word;

    audio_bclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_bclk (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .sck_o      (sck_o),
        .fall_tick_o(fall_tick)
    );

    assign sample_ready_o = ~holding_full;
    assign load           = sample_valid_i & ~holding_full;

    // Position of the bit about to be launched, and the ws level that goes
    // with it; ws leads the slot it announces by one bit clock.
    always_comb begin
        bit_nxt  = bit_cnt + 1'b1;
        slot_nxt = slot_cnt;
        if (bit_cnt == BIT_LAST) begin
            bit_nxt  = '0;
            slot_nxt = (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
        end
        boundary = fall_tick && (bit_nxt == '0) && (slot_nxt == '0);
        if (mode_q == AUDIO_MODE_TDM) begin
            ws_nxt = (bit_nxt == BIT_LAST) && (slot_nxt == SLOT_LAST);
        end else begin
            ws_nxt = (bit_nxt == BIT_LAST) ? ~slot_nxt[0] : slot_nxt[0];
        end
    end

    // Wire-order frame image: each channel left-justified in its slot.
    always_comb begin
        frame_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            frame_word[FRAME_W-1-k*SLOT_W -: AUDIO_DW] = holding[AUDIO_DW*k +: AUDIO_DW];
        end
        load_word = holding_full ? frame_word : '0;
    end

    // Mode is frozen while transmitting so a frame never mixes framings.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            mode_q <= mode_i;
        end
    end

    // A load coinciding with the boundary is not forwarded: the boundary
    // drains the old (possibly empty) contents and the new frame waits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            holding      <= '0;
            holding_full <= 1'b0;
            underrun_o   <= 1'b0;
        end else begin
            if (load) begin
                holding      <= sample_i;
                holding_full <= 1'b1;
            end else if (boundary) begin
                holding_full <= 1'b0;
            end
            if (boundary && !holding_full) begin
                underrun_o <= 1'b1;
            end else if (underrun_clr_i) begin
                underrun_o <= 1'b0;
            end
        end
    end

    // Parked on the last bit of the frame so the first fall tick after
    // enable lands exactly on a frame boundary.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            bit_cnt       <= BIT_LAST;
            slot_cnt      <= SLOT_LAST;
            shift_reg     <= '0;
            sd_o          <= 1'b0;
            ws_o          <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            frame_start_o <= boundary;
            if (fall_tick) begin
                bit_cnt  <= bit_nxt;
                slot_cnt <= slot_nxt;
                ws_o     <= ws_nxt;
                if (boundary) begin
                    sd_o      <= load_word[FRAME_W-1];
                    shift_reg <= {load_word[FRAME_W-2:0], 1'b0};
                end else begin
                    sd_o      <= shift_reg[FRAME_W-1];
                    shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_audio_tx.sv
// Directed bench for tdm_audio_tx: default 2-channel I2S/TDM instance plus a
// 4-channel TDM instance for the frame-sync lead checks.
module tb_tdm_audio_tx;

    logic        clk = 1'b0;
    logic        rst, en, mode, valid, clr;
    logic [15:0] sample;
    logic        ready, sck, ws, sd, fs, ur;

    logic        en4, mode4, valid4, clr4;
    logic [31:0] sample4;
    logic        ready4, sck4, ws4, sd4, fs4, ur4;

    int          n_vec;
    int          n_miss;
    bit          count_mode;
    logic [7:0]  cnt;

    typedef struct {
        logic [7:0]  ch0;
        logic [7:0]  ch1;
        logic        mode;
        logic [31:0] exp_sd;
        logic [31:0] exp_ws;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    tdm_audio_tx dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode),
        .sample_i(sample), .sample_valid_i(valid), .sample_ready_o(ready),
        .underrun_clr_i(clr), .sck_o(sck), .ws_o(ws), .sd_o(sd),
        .frame_start_o(fs), .underrun_o(ur)
    );

    tdm_audio_tx #(.AUDIO_DW(8), .SLOT_W(8), .NUM_CH(4), .CLK_DIV(2)) dut4 (
        .clk_i(clk), .rst_i(rst), .en_i(en4), .mode_i(mode4),
        .sample_i(sample4), .sample_valid_i(valid4), .sample_ready_o(ready4),
        .underrun_clr_i(clr4), .sck_o(sck4), .ws_o(ws4), .sd_o(sd4),
        .frame_start_o(fs4), .underrun_o(ur4)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic m,
                                 input logic v, input logic c, input logic [15:0] s);
        rst = r; en = e; mode = m; valid = v; clr = c; sample = s;
    endtask

    // One clock; in counting mode the offered frame advances after each accepted load.
    task automatic tick();
        bit loading;
        loading = count_mode && valid && ready;
        @(posedge clk);
        #1;
        if (loading) begin
            cnt    = cnt + 8'd1;
            sample = {cnt + 8'h40, cnt};
        end
    endtask

    task automatic capture_frame(output logic [31:0] sd_s, output logic [31:0] ws_s,
                                 output logic rdy_start);
        int n = 0;
        sd_s = '0;
        ws_s = '0;
        rdy_start = 1'b0;
        while (fs !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (fs !== 1'b1) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL capture_timeout: got no frame_start, expected one within 300 cycles");
        end else begin
            rdy_start = ready;
            for (int i = 0; i < 32; i++) begin
                sd_s[31-i] = sd;
                ws_s[31-i] = ws;
                if (i < 31) repeat (4) tick();
            end
        end
    endtask

    task automatic do_reset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 2000000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] got_sd, got_ws;
        logic        got_rdy;
        logic [3:0]  sck_pat;
        logic [7:0]  kk;
        int          n;
        int          ws_cnt;
        logic        ws_prev;

        n_vec = 0;
        n_miss = 0;
        count_mode = 1'b0;
        cnt = 8'd0;
        en4 = 1'b0; mode4 = 1'b1; valid4 = 1'b0; clr4 = 1'b0; sample4 = '0;
        sck_pat = 4'b0110;

        vecs[0] = '{8'hA5, 8'h3C, 1'b0, 32'hA5003C00, 32'h0001FFFE};
        vecs[1] = '{8'hFF, 8'h01, 1'b1, 32'hFF000100, 32'h00000001};
        vecs[2] = '{8'h80, 8'h00, 1'b0, 32'h80000000, 32'h0001FFFE};
        vecs[3] = '{8'h5A, 8'hC3, 1'b1, 32'h5A00C300, 32'h00000001};

        // Reset state, then enable with no samples queued.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        checkOutput("reset_outputs", {27'd0, sck, ws, sd, fs, ur}, 32'd0);
        checkOutput("reset_ready", ready, 1'b1);
        rst = 1'b0;
        en = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tick();
            checkOutput("t1_sck", sck, sck_pat[t-1]);
            if (t == 3) checkOutput("t1_pre_tick", {fs, ur}, 2'b00);
            if (t == 4) checkOutput("t1_first_tick", {fs, ur}, 2'b11);
        end
        capture_frame(got_sd, got_ws, got_rdy);
        checkOutput("t1_sd_zero", got_sd, 32'h00000000);
        checkOutput("t1_ws_i2s", got_ws, 32'h0001FFFE);
        checkOutput("t1_fs_pulse", fs, 1'b0);

        // Table: preloaded frames in both modes.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            mode = vecs[v].mode;
            sample = {vecs[v].ch1, vecs[v].ch0};
            valid = 1'b1;
            tick();
            valid = 1'b0;
            checkOutput("tbl_ready_busy", ready, 1'b0);
            en = 1'b1;
            capture_frame(got_sd, got_ws, got_rdy);
            checkOutput("tbl_sd", got_sd, vecs[v].exp_sd);
            checkOutput("tbl_ws", got_ws, vecs[v].exp_ws);
            checkOutput("tbl_ready_after", got_rdy, 1'b1);
            checkOutput("tbl_underrun", ur, 1'b0);
            en = 1'b0;
            tick();
        end

        // 4-channel TDM: ws pulse of one bit clock right before each frame.
        do_reset();
        en4 = 1'b1;
        n = 0;
        while (fs4 !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checkOutput("t3_first_fs", fs4, 1'b1);
        for (int f = 0; f < 3; f++) begin
            n = 0;
            ws_cnt = 0;
            ws_prev = 1'b0;
            do begin
                tick();
                n++;
                if (fs4 !== 1'b1) begin
                    ws_cnt += int'(ws4);
                    ws_prev = ws4;
                end
            end while (fs4 !== 1'b1 && n < 300);
            checkOutput("t3_period", n, 128);
            checkOutput("t3_ws_width", ws_cnt, 4);
            checkOutput("t3_ws_lead", ws_prev, 1'b1);
            checkOutput("t3_ws_at_start", ws4, 1'b0);
        end
        en4 = 1'b0;

        // Continuous valid with counting data.
        do_reset();
        count_mode = 1'b1;
        cnt = 8'd1;
        sample = {8'h41, 8'h01};
        valid = 1'b1;
        tick();
        checkOutput("t4_ready_loaded", ready, 1'b0);
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            kk = 8'(k);
            capture_frame(got_sd, got_ws, got_rdy);
            checkOutput("t4_frame", got_sd, {kk, 8'h00, kk + 8'h40, 8'h00});
            checkOutput("t4_ready_at_start", got_rdy, 1'b1);
            checkOutput("t4_ready_mid", ready, 1'b0);
        end
        valid = 1'b0;
        count_mode = 1'b0;
        checkOutput("t4_underrun", ur, 1'b0);
        en = 1'b0;
        tick();

        // Valid arriving on the boundary edge with an empty buffer.
        do_reset();
        en = 1'b1;
        for (int t = 1; t <= 131; t++) begin
            clr = (t == 100);
            tick();
        end
        checkOutput("t5_cleared", {fs, ur}, 2'b00);
        valid = 1'b1;
        clr = 1'b1;
        sample = {8'h81, 8'hC3};
        tick();
        valid = 1'b0;
        clr = 1'b0;
        checkOutput("t5_boundary", {fs, ur, ready, sd}, 4'b1100);
        capture_frame(got_sd, got_ws, got_rdy);
        checkOutput("t5_zero_frame", got_sd, 32'h00000000);
        capture_frame(got_sd, got_ws, got_rdy);
        checkOutput("t5_next_frame", got_sd, 32'hC3008100);
        checkOutput("t5_ready", got_rdy, 1'b1);
        checkOutput("t5_sticky", ur, 1'b1);
        en = 1'b0;
        tick();

        // Reset in the middle of a slot, then a clean restart.
        do_reset();
        en = 1'b1;
        repeat (50) tick();
        checkOutput("t6_pre_underrun", ur, 1'b1);
        rst = 1'b1;
        tick();
        checkOutput("t6_reset_outputs", {27'd0, sck, ws, sd, fs, ur}, 32'd0);
        checkOutput("t6_reset_ready", ready, 1'b1);
        rst = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            tick();
            checkOutput("t6_sck", sck, sck_pat[t-1]);
            if (t == 4) checkOutput("t6_first_tick", {fs, ur}, 2'b11);
        end
        capture_frame(got_sd, got_ws, got_rdy);
        checkOutput("t6_sd_zero", got_sd, 32'h00000000);
        checkOutput("t6_ws_i2s", got_ws, 32'h0001FFFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
